vid_timing_gen: RTL and testbench
=================================

# vid_timing_gen

Raster timing generator for the video display processor. It runs a horizontal pixel counter and a vertical line counter through active, front-porch, sync and back-porch intervals. It produces the pixel coordinates, sync pulses and data-enable that the downstream pixel fetch and output stages consume. It is the direct consumer of the team's up/down counter primitive behaviour (count, wrap, overflow), specialised to fixed-period up-counting with region decode.

## Interface

Parameters:

- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `HW`, 10: hcount width
- `VW`, 10: vcount width
- `SYNC_POL`, 0: sync level while asserted (0 = active-low)

Ports:

- `c` in 1: clock (pixel clock)
- `clr` in 1: reset, synchronous, active-high
- `en` in 1: pixel advance enable
- `hcount` out HW: current pixel column, 0..H_TOTAL-1
- `vcount` out VW: current line, 0..V_TOTAL-1
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `de` out 1: data enable, high inside the active area
- `line_start` out 1: one-cycle pulse on entering hcount=0
- `frame_start` out 1: one-cycle pulse on entering (0,0)

## Operation

- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Legal configuration: every interval ≥1, H_TOTAL ≤ 2^HW and V_TOTAL ≤ 2^VW. Illegal values are flagged by an elaboration-time check.
- Horizontal FSM states: H_ACT → H_FP → H_SYNC → H_BP → H_ACT.
  - A transition occurs when hcount reaches the last pixel of the current interval and `en`=1.
  - hcount wraps from H_TOTAL-1 to 0.
- Vertical FSM states: V_ACT → V_FP → V_SYNC → V_BP → V_ACT.
  - The vertical FSM advances only on the horizontal wrap edge.
  - vcount wraps from V_TOTAL-1 to 0.
- Region decode:
  - `de`=1 iff hcount<H_ACTIVE and vcount<V_ACTIVE.
  - `hsync`=SYNC_POL iff hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise ~SYNC_POL.
  - `vsync`=SYNC_POL for whole lines with vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; otherwise ~SYNC_POL.
- Reset state is the last position of a frame: hcount=H_TOTAL-1, vcount=V_TOTAL-1, states H_BP/V_BP, `de`=0, `hsync`=`vsync`=~SYNC_POL, `line_start`=`frame_start`=0. The first enabled edge after reset therefore enters (0,0).
- `en`=0: counters, FSM states, `de` and syncs hold. `line_start`/`frame_start` are 0 in any cycle not preceded by an enabled edge.
- `clr` overrides `en`. `clr` asserted mid-frame restores reset values on the next edge; there is no partial-line completion.

## Timing

- All outputs are registered and computed from next-state values. `de`, `hsync`, `vsync` and the pulses are cycle-aligned with the `hcount`/`vcount` they describe, with zero skew between them.
- Position latency: an enabled edge updates every output in the same cycle as the new coordinates.
- `line_start` is high exactly one cycle per line when en stays high. `frame_start` coincides with `line_start` at vcount=0.
- Frame period with en continuously high: H_TOTAL×V_TOTAL cycles between `frame_start` pulses.
- vsync edges align with hcount=0 (line boundary), not with hsync.

## Structure

- Package `vid_timing_pkg`:
  - 2-bit region state encoding (ACT, FP, SYNC, BP), shared by both axes
  - default 640×480@60 interval constants
  - a small test-mode constant set
- Sub-module `tg_axis`, instantiated twice (horizontal, vertical):
  - parameterised by the four interval lengths and the counter width
  - inputs: `c`, `clr`, step enable
  - outputs: count, state, in-sync flag, wrap flag
- The horizontal wrap flag AND `en` drives the vertical step.
- Top-level logic covers the `de` decode, sync polarity and pulse generation.

## Test plan

Test parameters: H 8/2/3/3 (H_TOTAL=16), V 4/1/1/2 (V_TOTAL=8), HW=VW=4, SYNC_POL=0.

1. `clr`=1 for 2 cycles → hcount=15, vcount=7, de=0, hsync=vsync=1, line_start=frame_start=0.
2. Release `clr` with en=1 → next edge gives (0,0), de=1, frame_start=1, line_start=1. On line 0, de is high for hcount 0..7 and low for 8..15. The next frame_start arrives 128 cycles later.
3. Each line: hsync=0 exactly at hcount 10, 11, 12, and 1 elsewhere. line_start is high only at hcount=0, every 16 cycles.
4. vsync=0 for the whole of vcount=5 (16 cycles, hcount 0..15) and 1 elsewhere. de=0 for all of vcount 4..7.
5. Drop en at (5,1) for 4 cycles → all outputs hold at (5,1), pulses 0. The first enabled edge after en returns gives hcount=6.
6. Assert `clr` at (9,2) → next edge gives reset values. Releasing it restarts at (0,0) with frame_start=1.

Source files
------------

// File: rtl/vid_timing_pkg.sv
// vid_timing_pkg: shared definitions for the raster timing generator.
//   region_e      - 2-bit region state for either axis (ACT, FP, SYNC, BP)
//   DEF_*         - 640x480@60 interval constants (default configuration)
//   TM_*          - small test-mode configuration (16 x 8 raster)
package vid_timing_pkg;

  typedef enum logic [1:0] {
    ST_ACT  = 2'd0,
    ST_FP   = 2'd1,
    ST_SYNC = 2'd2,
    ST_BP   = 2'd3
  } region_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_HW       = 10;
  localparam int DEF_VW       = 10;

  localparam int TM_H_ACTIVE = 8;
  localparam int TM_H_FP     = 2;
  localparam int TM_H_SYNC   = 3;
  localparam int TM_H_BP     = 3;
  localparam int TM_V_ACTIVE = 4;
  localparam int TM_V_FP     = 1;
  localparam int TM_V_SYNC   = 1;
  localparam int TM_V_BP     = 2;
  localparam int TM_HW       = 4;
  localparam int TM_VW       = 4;

endpackage

// File: rtl/vid_timing_gen_tg_axis.sv
// tg_axis: one raster axis. Fixed-period up-counter with region FSM.
//   c, clr      - clock, synchronous active-high reset
//   step        - advance one position this edge
//   count       - registered position, 0..TOTAL-1 (resets to TOTAL-1)
//   state       - registered region state (resets to ST_BP)
//   act_nxt     - next-cycle position is in the active region
//   sync_nxt    - next-cycle position is in the sync region
//   wrap        - this edge steps from TOTAL-1 back to 0
module tg_axis
  import vid_timing_pkg::*;
#(
  parameter int L_ACT  = 8,
  parameter int L_FP   = 2,
  parameter int L_SYNC = 3,
  parameter int L_BP   = 3,
  parameter int W      = 4
) (
  input  logic         c,
  input  logic         clr,
  input  logic         step,
  output logic [W-1:0] count,
  output region_e      state,
  output logic         act_nxt,
  output logic         sync_nxt,
  output logic         wrap
);

  localparam int TOTAL = L_ACT + L_FP + L_SYNC + L_BP;

  // Last position of each interval.
  localparam logic [W-1:0] E_ACT  = W'(L_ACT - 1);
  localparam logic [W-1:0] E_FP   = W'(L_ACT + L_FP - 1);
  localparam logic [W-1:0] E_SYNC = W'(L_ACT + L_FP + L_SYNC - 1);
  localparam logic [W-1:0] E_BP   = W'(TOTAL - 1);

  logic [W-1:0] r_cnt;
  region_e      r_st;
  logic [W-1:0] w_cnt_nxt;
  region_e      w_st_nxt;

  always_ff @(posedge c) begin
    if (clr) begin
      r_cnt <= E_BP;
      r_st  <= ST_BP;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_st  <= w_st_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_st_nxt  = r_st;
    wrap      = 1'b0;
    if (step) begin
      if (r_cnt == E_BP) begin
        w_cnt_nxt = '0;
        wrap      = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      unique case (r_st)
        ST_ACT:  if (r_cnt == E_ACT)  w_st_nxt = ST_FP;
        ST_FP:   if (r_cnt == E_FP)   w_st_nxt = ST_SYNC;
        ST_SYNC: if (r_cnt == E_SYNC) w_st_nxt = ST_BP;
        ST_BP:   if (r_cnt == E_BP)   w_st_nxt = ST_ACT;
        default: w_st_nxt = ST_BP;
      endcase
    end
  end

  assign count    = r_cnt;
  assign state    = r_st;
  assign act_nxt  = (w_st_nxt == ST_ACT);
  assign sync_nxt = (w_st_nxt == ST_SYNC);

endmodule

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster timing generator.
//   c, clr, en          - pixel clock, sync active-high reset, advance enable
//   hcount, vcount      - current pixel column / line
//   hsync, vsync        - sync pulses, level SYNC_POL while asserted
//   de                  - data enable inside the active area
//   line_start          - one-cycle pulse on entering hcount=0
//   frame_start         - one-cycle pulse on entering (0,0)
// All decoded outputs are registered from next-state values so they line
// up with the counters they describe.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   HW       = DEF_HW,
  parameter int   VW       = DEF_VW,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic          c,
  input  logic          clr,
  input  logic          en,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_cfg_err
    $error("vid_timing_gen: illegal interval/width configuration");
  end

  logic    w_h_act_nxt, w_h_sync_nxt, w_h_wrap;
  logic    w_v_act_nxt, w_v_sync_nxt, w_v_wrap;
  logic    w_v_step;
  region_e w_h_state, w_v_state;

  logic r_de, r_hsync, r_vsync, r_line_start, r_frame_start;

  tg_axis #(
    .L_ACT (H_ACTIVE),
    .L_FP  (H_FP),
    .L_SYNC(H_SYNC),
    .L_BP  (H_BP),
    .W     (HW)
  ) u_h_axis (
    .c       (c),
    .clr     (clr),
    .step    (en),
    .count   (hcount),
    .state   (w_h_state),
    .act_nxt (w_h_act_nxt),
    .sync_nxt(w_h_sync_nxt),
    .wrap    (w_h_wrap)
  );

  assign w_v_step = w_h_wrap & en;

  tg_axis #(
    .L_ACT (V_ACTIVE),
    .L_FP  (V_FP),
    .L_SYNC(V_SYNC),
    .L_BP  (V_BP),
    .W     (VW)
  ) u_v_axis (
    .c       (c),
    .clr     (clr),
    .step    (w_v_step),
    .count   (vcount),
    .state   (w_v_state),
    .act_nxt (w_v_act_nxt),
    .sync_nxt(w_v_sync_nxt),
    .wrap    (w_v_wrap)
  );

  // With en=0 the next states equal the current ones and the wrap flags are
  // low, so de/syncs hold and the pulses drop without extra gating.
  always_ff @(posedge c) begin
    if (clr) begin
      r_de          <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_de          <= w_h_act_nxt & w_v_act_nxt;
      r_hsync       <= w_h_sync_nxt ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_v_sync_nxt ? SYNC_POL : ~SYNC_POL;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap & w_v_wrap;
    end
  end

  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

  // Region states are exposed by the axis for debug; not needed for decode.
  logic w_unused;
  assign w_unused = ^{w_h_state, w_v_state};

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb_vid_timing_gen: scoreboard bench for vid_timing_gen in the 16x8 test
// configuration. The stimulus process drives clr/en on the falling edge and
// pushes the expected post-edge outputs; the monitor pops and compares after
// each rising edge.
module tb_vid_timing_gen;
  import vid_timing_pkg::*;

  localparam int HT = TM_H_ACTIVE + TM_H_FP + TM_H_SYNC + TM_H_BP;  // 16
  localparam int VT = TM_V_ACTIVE + TM_V_FP + TM_V_SYNC + TM_V_BP;  // 8

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] v;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  logic       c = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic [3:0] hcount, vcount;
  logic       hsync, vsync, de, line_start, frame_start;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference position (starts at the reset position).
  int mh = HT - 1;
  int mv = VT - 1;
  logic mls = 1'b0, mfs = 1'b0;

  vid_timing_gen #(
    .H_ACTIVE(TM_H_ACTIVE), .H_FP(TM_H_FP), .H_SYNC(TM_H_SYNC), .H_BP(TM_H_BP),
    .V_ACTIVE(TM_V_ACTIVE), .V_FP(TM_V_FP), .V_SYNC(TM_V_SYNC), .V_BP(TM_V_BP),
    .HW(TM_HW), .VW(TM_VW), .SYNC_POL(1'b0)
  ) dut (
    .c(c), .clr(clr), .en(en),
    .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .de(de),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 c = ~c;

  // Drive one cycle and queue what the outputs must be after its rising edge.
  // Expected regions are hand-written ranges: active h<8 & v<4,
  // hsync low at h 10..12, vsync low on line 5.
  task automatic step(input logic clr_v, input logic en_v);
    obs_t e;
    @(negedge c);
    clr = clr_v;
    en  = en_v;
    if (clr_v) begin
      mh = HT - 1; mv = VT - 1; mls = 1'b0; mfs = 1'b0;
    end else if (en_v) begin
      mh = (mh + 1) % HT;
      if (mh == 0) mv = (mv + 1) % VT;
      mls = (mh == 0);
      mfs = (mh == 0) && (mv == 0);
    end else begin
      mls = 1'b0; mfs = 1'b0;
    end
    e.h  = 4'(mh);
    e.v  = 4'(mv);
    e.de = (mh < 8) && (mv < 4) && !clr_v;
    e.hs = !((mh >= 10) && (mh <= 12));
    e.vs = (mv != 5);
    e.ls = mls;
    e.fs = mfs;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic clr_v, input logic en_v);
    for (int i = 0; i < n; i++) step(clr_v, en_v);
  endtask

  // Monitor: every cycle with a queued expectation is a DUT output beat.
  initial begin
    obs_t got, e;
    forever begin
      @(posedge c);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{h: hcount, v: vcount, de: de, hs: hsync, vs: vsync,
                ls: line_start, fs: frame_start};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL cyc%0d outputs: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b, expected h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                   cyc, got.h, got.v, got.de, got.hs, got.vs, got.ls, got.fs,
                   e.h, e.v, e.de, e.hs, e.vs, e.ls, e.fs);
        end
      end
    end
  end

  initial begin
    // 1. reset for two cycles -> (15,7), idle levels
    run(2, 1'b1, 1'b0);
    // 2-4. two full frames from (0,0): pulses, de, hsync, vsync, 128-cycle period
    run(2 * HT * VT, 1'b0, 1'b1);
    // advance to (5,1)
    run(HT + 6, 1'b0, 1'b1);
    // 5. hold for 4 cycles, then resume (first edge -> hcount 6)
    run(4, 1'b0, 1'b0);
    // advance to (9,2)
    run(20, 1'b0, 1'b1);
    // alternating enable across a line boundary
    for (int i = 0; i < 24; i++) step(1'b0, 1'(i % 2));
    // 6. clear mid-frame, then restart at (0,0) with frame_start
    run(1, 1'b1, 1'b1);
    run(20, 1'b0, 1'b1);
    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge c);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
